// File: rtl/bus_xfer_sequencer.sv
// Register-to-register transfer sequencer for the shared w_bus: queues requests in a
// 2-entry FIFO and runs each as a DRIVE cycle followed by a LATCH cycle.
module bus_xfer_sequencer #(
    parameter int N_REGS = 9,
    parameter int SRC_W  = 4
) (
    input  logic              one_shot_clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SRC_W-1:0]  req_src,
    input  logic [N_REGS-1:0] req_dst,
    output logic [N_REGS-1:0] enable_out,
    output logic              ext_drive,
    output logic [N_REGS-1:0] latch_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        xfer_count,
    output logic [1:0]        fsm_state
);

    // Request handshake: an entry {req_src, req_dst} is taken on any rising edge where
    // req_valid && req_ready; the requester must hold the request while req_ready is low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SRC_W-1:0]  fifo_src [2];
    logic [N_REGS-1:0] fifo_dst [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        occ;
    logic              push, pop;

    logic [SRC_W-1:0]  cur_src, cur_src_nxt;
    logic [N_REGS-1:0] cur_dst, cur_dst_nxt;
    logic              head_ok, self_xfer;
    logic              done_nxt, err_nxt;
    logic [N_REGS-1:0] enable_nxt, latch_nxt;
    logic              ext_nxt;

    // Ready looks only at occupancy before this edge, so a full FIFO gets no same-edge credit.
    assign req_ready = (occ != 2'd2);
    assign push      = req_valid && req_ready;
    assign busy      = (state != IDLE) || (occ != 2'd0);
    assign fsm_state = state;

    always_comb begin
        self_xfer = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (fifo_src[rd_ptr] == SRC_W'(i) && fifo_dst[rd_ptr][i]) self_xfer = 1'b1;
        end
        head_ok = (fifo_src[rd_ptr] <= SRC_W'(N_REGS)) && (fifo_dst[rd_ptr] != '0) && !self_xfer;
    end

    always_comb begin
        state_nxt   = state;
        cur_src_nxt = cur_src;
        cur_dst_nxt = cur_dst;
        pop         = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (occ != 2'd0) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        state_nxt   = DRIVE;
                        cur_src_nxt = fifo_src[rd_ptr];
                        cur_dst_nxt = fifo_dst[rd_ptr];
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DRIVE: state_nxt = LATCH;
            LATCH: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
                if (occ != 2'd0) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        state_nxt   = DRIVE;
                        cur_src_nxt = fifo_src[rd_ptr];
                        cur_dst_nxt = fifo_dst[rd_ptr];
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobes are decoded from the next state so they come straight out of flops.
        enable_nxt = '0;
        ext_nxt    = 1'b0;
        latch_nxt  = '0;
        if (state_nxt != IDLE) begin
            for (int i = 0; i < N_REGS; i++) enable_nxt[i] = (cur_src_nxt == SRC_W'(i));
            ext_nxt = (cur_src_nxt == SRC_W'(N_REGS));
        end
        if (state_nxt == LATCH) latch_nxt = cur_dst_nxt;
    end

    always_ff @(posedge one_shot_clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            cur_src    <= '0;
            cur_dst    <= '0;
            enable_out <= '0;
            ext_drive  <= 1'b0;
            latch_out  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            cur_src    <= cur_src_nxt;
            cur_dst    <= cur_dst_nxt;
            enable_out <= enable_nxt;
            ext_drive  <= ext_nxt;
            latch_out  <= latch_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            if (done_nxt) xfer_count <= xfer_count + 8'd1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge one_shot_clock) begin
        if (push) begin
            fifo_src[wr_ptr] <= req_src;
            fifo_dst[wr_ptr] <= req_dst;
        end
    end

endmodule

// File: doc/bus_xfer_sequencer.md
# bus_xfer_sequencer

Sequences register-to-register transfers over the shared 16-bit `w_bus`. It drives the per-register `enable` (bus driver) and `latch` (bus capture) strobes for GPR, MDR, IR, timer, conrom, MAR, Y, Z and PSW, plus the external bus driver. It guarantees that at most one driver is active in any cycle. Requests are buffered in a 2-entry FIFO and executed in order as a DRIVE cycle followed by a LATCH cycle.

## Interface
- `N_REGS`, 9: number of bus registers. Index map: 0 GPR, 1 MDR, 2 IR, 3 timer, 4 conrom, 5 MAR, 6 Y, 7 Z, 8 PSW. Index `N_REGS` selects the external driver.
- `SRC_W`, 4: width of the source index.
- `one_shot_clock`  in  1: clock. All state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: a transfer request is presented.
- `req_ready`  out  1: the FIFO can accept a request. Equals "FIFO not full".
- `req_src`  in  SRC_W: source index, 0..N_REGS.
- `req_dst`  in  N_REGS: one-hot-or-multi destination mask.
- `enable_out`  out  N_REGS: per-register bus-drive strobes. Registered; at most one bit set.
- `ext_drive`  out  1: external driver owns the bus. Registered; mutually exclusive with `enable_out`.
- `latch_out`  out  N_REGS: per-register capture strobes. Registered.
- `busy`  out  1: FSM is in DRIVE or LATCH, or the FIFO is non-empty.
- `done`  out  1: one-cycle pulse after each completed transfer.
- `err`  out  1: one-cycle pulse when a popped request is rejected.
- `xfer_count`  out  8: count of completed transfers; wraps from 255 to 0.

## Operation
- **Accept.** A request is accepted on any edge where `req_valid && req_ready`. The entry `{src, dst}` is written to the FIFO tail. When the FIFO is full, `req_ready` is 0 and the request is ignored, not dropped silently into the FIFO. The requester must hold it.
- **Validation at pop.** A request is rejected if any of these hold:
  - `src > N_REGS`;
  - `dst == 0`;
  - `src < N_REGS` and `dst[src]` is set (self-transfer).
- On rejection: `err` pulses, no strobes are issued, the FSM stays in or returns to IDLE, and `xfer_count` is unchanged.
- **FSM states.**
  - IDLE: all strobes 0. If the FIFO is non-empty, pop the head. A valid head goes to DRIVE; an invalid head stays in IDLE and pulses `err`.
  - DRIVE: the source strobe is 1 (`enable_out[src]`, or `ext_drive` if `src == N_REGS`); `latch_out` is 0. Always goes to LATCH.
  - LATCH: the source strobe is held and `latch_out = dst`. On the edge leaving LATCH, the destination registers capture `w_bus`.
    - `done` pulses and `xfer_count` increments.
    - If the FIFO is non-empty, pop: a valid head goes to DRIVE, an invalid head goes to IDLE with an `err` pulse.
    - If the FIFO is empty, go to IDLE.
- **FIFO.** Simultaneous push and pop in the same edge is allowed when not full, and the occupancy is unchanged. Pointers wrap modulo 2.
- **Invariant.** In every cycle, `enable_out` plus `ext_drive` together have at most one bit set. `latch_out` is non-zero only in LATCH.

## Timing
- **Reset values.** All strobes, `done` and `err` are 0. `xfer_count` is 0, the FIFO is empty, the FSM is in IDLE, and `req_ready` is 1 on the first cycle after reset.
- **Reset mid-transfer.** At the reset edge, the FIFO is flushed and the FSM goes to IDLE. All strobes are 0 in the following cycle. No `done` pulse and no count increment occur for the aborted transfer.
- **Latency, isolated request accepted at edge E0:**
  - E1: pop; DRIVE during E1→E2.
  - E2: LATCH during E2→E3.
  - E3: destinations capture; `done` is high during E3→E4.
- **Throughput.** Back-to-back valid requests take 2 cycles each. The `done` pulse for transfer *k* coincides with the DRIVE cycle of *k*+1.
- **Rejection timing.** An invalid head popped at edge E produces `err` high during E→E+1.
- **`busy`** is combinational from state and FIFO occupancy.
- **`req_ready`** is combinational from FIFO occupancy. It reflects occupancy before the current edge's pop, so no same-edge credit is given when the FIFO is full.

## Test plan
- **Single transfer.** After reset, push `src=0` (GPR), `dst=9'b000100000` (MAR) at E0.
  - `enable_out=9'h001` during E1–E3.
  - `latch_out=9'h020` only during E2–E3.
  - `done` high during E3–E4; `xfer_count=1`.
- **Back-to-back with full FIFO.** Push 3 requests on consecutive edges (Y→Z, Z→MDR, ext→IR).
  - `req_ready` drops to 0 after 2 entries are held; the third is accepted once space frees.
  - The three DRIVE/LATCH pairs run with no IDLE gap; there are 3 `done` pulses.
  - `ext_drive=1` only during the third transfer.
- **Rejections.** Push `src=10`, then `dst=0`, then `src=6`/`dst` including Y.
  - 3 `err` pulses, no strobes, `xfer_count` unchanged.
  - A following valid request executes normally.
- **Multi-destination.** Push `src=1`, `dst=9'b110000001`; `latch_out=9'h181` in the LATCH cycle.
- **Reset mid-operation.** Assert `reset` during a LATCH cycle with 1 entry queued.
  - All strobes are 0 in the next cycle, the FIFO is empty, and no `done` pulse occurs.
  - `xfer_count=0`.
- **Count wrap.** Complete 256 valid transfers; `xfer_count` returns to 0. Check the bus-exclusivity invariant every cycle.
